instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 2, SHALL set the PC increment after each delivered instruction, in bytes.
REQ-003 clock  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_en  input  1  SHALL be the control request to fetch the instruction at pc.
REQ-006 pc_load  input  1  SHALL be the redirect strobe for branch or jump.
REQ-007 pc_next  input  16  SHALL be the redirect target, sampled when pc_load=1.
REQ-008 mem_req  output  1  SHALL be the instruction memory read request.
REQ-009 mem_addr  output  16  SHALL be the memory read address and SHALL equal pc whenever mem_req=1.
REQ-010 mem_ready  input  1  SHALL be the memory acknowledge, meaning mem_data is valid this cycle.
REQ-011 mem_data  input  16  SHALL be the instruction word returned by memory.
REQ-012 IR_in  output  16  SHALL carry the fetched word to the instruction register.
REQ-013 IRWrite  output  1  SHALL be a one-cycle strobe marking IR_in valid.
REQ-014 pc  output  16  SHALL be the current program counter.
REQ-015 busy  output  1  SHALL be 1 in every state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ and DELIVER.
REQ-017 IDLE: if pc_load=1, pc SHALL load pc_next and the state SHALL stay IDLE; else if fetch_en=1, the next state SHALL be REQ.
REQ-018 REQ: mem_req SHALL be 1 and mem_addr SHALL be held stable until mem_ready=1.
REQ-019 REQ with mem_ready=1 and pc_load=0: IR_in SHALL register mem_data and the next state SHALL be DELIVER.
REQ-020 DELIVER: IRWrite SHALL be 1 for exactly this cycle, pc SHALL advance by PC_STEP modulo 2^16, and the next state SHALL be IDLE.
REQ-021 Fetch latency SHALL be: fetch_en sampled, then at least 1 REQ cycle, then IRWrite exactly 1 cycle after the mem_ready cycle; the minimum is 3 cycles from fetch_en to IRWrite.
REQ-022 pc_load=1 in REQ SHALL set a discard flag, load pc from pc_next, and keep mem_req until mem_ready; the returned word SHALL then be dropped, IRWrite SHALL stay 0, and the next state SHALL be IDLE.
REQ-023 pc_load and mem_ready both 1 in REQ SHALL drop the word; pc SHALL become pc_next and the next state SHALL be IDLE.
REQ-024 pc_load=1 in DELIVER SHALL take priority over the increment: pc SHALL equal pc_next and IRWrite SHALL still pulse.
REQ-025 PC wrap: pc=16'hFFFE with PC_STEP=2 SHALL advance to 16'h0000 with no flag raised.
REQ-026 IR_in SHALL hold its value between deliveries.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, IR_in=16'h0000, and IRWrite, mem_req, busy and the discard flag to 0, and (if compiled) timeout=0 and the watchdog counter to 0.
REQ-028 Reset asserted mid-fetch SHALL abandon the request; a late mem_ready SHALL be ignored in IDLE.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN, when defined, SHALL add output timeout (1 bit) and a 4-bit watchdog counter that counts REQ cycles with mem_ready=0.
REQ-030 With the macro defined, when the counter reaches 15, timeout SHALL be set sticky until reset, the request SHALL be abandoned, and the state SHALL return to IDLE with no IRWrite.
REQ-031 Without the macro, no timeout port or counter SHALL exist, and REQ SHALL wait on mem_ready indefinitely.

Verification
REQ-032 Reset then fetch_en=1 with a 0-wait memory returning 16'h1234: mem_addr=0000, IRWrite pulses once with IR_in=1234, then pc=0002.
REQ-033 3-wait-state memory: mem_req held for 4 cycles with mem_addr stable, IRWrite exactly 1 cycle after mem_ready.
REQ-034 pc_load=1 with pc_next=16'h0040 in REQ: returned word discarded, IRWrite=0, pc=0040, next fetch addresses 0040.
REQ-035 pc=FFFE, fetch completes: pc=0000; pc_load with 0x0100 during DELIVER gives pc=0100 and IRWrite still pulses.
REQ-036 reset_n pulsed low mid-REQ: outputs reach reset values asynchronously, and a later mem_ready causes no IRWrite.
REQ-037 FETCH_TIMEOUT_EN defined, mem_ready tied to 0: timeout=1 after 15 REQ cycles, state IDLE, timeout stays set until reset.

Source files
------------

// File: rtl/instruction_fetch.sv
// Three-state instruction fetch unit: IDLE -> REQ -> DELIVER, with PC redirect and discard.
// Optional request watchdog: define FETCH_TIMEOUT_EN to add the timeout output and counter.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [15:0] pc_next,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic [15:0] IR_in,
  output logic        IRWrite,
  output logic [15:0] pc,
  output logic        busy
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DELIVER = 2'd2;

  localparam logic [15:0] STEP = 16'(PC_STEP);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] ir_nxt;
  logic        discard;
  logic        discard_nxt;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  wdog;
  logic [3:0]  wdog_nxt;
  logic        timeout_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = IR_in;
    discard_nxt = discard;

    case (state)
      IDLE: begin
        // A redirect in IDLE wins over starting a new fetch.
        if (pc_load) begin
          pc_nxt = pc_next;
        end else if (fetch_en) begin
          state_nxt   = REQ;
          discard_nxt = 1'b0;
        end
      end

      REQ: begin
        if (mem_ready) begin
          if (pc_load) begin
            pc_nxt = pc_next;
          end
          // The word belongs to the old PC once any redirect has been seen.
          if (pc_load || discard) begin
            state_nxt = IDLE;
          end else begin
            ir_nxt    = mem_data;
            state_nxt = DELIVER;
          end
          discard_nxt = 1'b0;
        end else if (pc_load) begin
          pc_nxt      = pc_next;
          discard_nxt = 1'b1;
        end
      end

      DELIVER: begin
        pc_nxt    = pc_load ? pc_next : pc + STEP;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt   = IDLE;
        discard_nxt = 1'b0;
      end
    endcase

`ifdef FETCH_TIMEOUT_EN
    wdog_nxt    = wdog;
    timeout_nxt = timeout;
    if (state == IDLE && !pc_load && fetch_en) begin
      wdog_nxt = 4'd0;
    end
    // The fifteenth unanswered REQ cycle abandons the request.
    if (state == REQ && !mem_ready) begin
      wdog_nxt = wdog + 4'd1;
      if (wdog == 4'd14) begin
        timeout_nxt = 1'b1;
        state_nxt   = IDLE;
        discard_nxt = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      IR_in   <= 16'h0000;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      IR_in   <= ir_nxt;
      discard <= discard_nxt;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog    <= 4'd0;
      timeout <= 1'b0;
    end else begin
      wdog    <= wdog_nxt;
      timeout <= timeout_nxt;
    end
  end
`endif

  // Outputs decode directly from state so reset clears them without waiting for a clock.
  assign mem_req  = (state == REQ);
  assign mem_addr = pc;
  assign IRWrite  = (state == DELIVER);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: basic fetch, wait states, redirects, wrap, reset, timeout.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic        fetch_en;
  logic        pc_load;
  logic [15:0] pc_next;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [15:0] IR_in;
  logic        IRWrite;
  logic [15:0] pc;
  logic        busy;
`ifdef FETCH_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int fails  = 0;

  instruction_fetch #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .fetch_en (fetch_en),
    .pc_load  (pc_load),
    .pc_next  (pc_next),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_data (mem_data),
    .IR_in    (IR_in),
    .IRWrite  (IRWrite),
    .pc       (pc),
    .busy     (busy)
`ifdef FETCH_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_en = 1'b0; pc_load = 1'b0; pc_next = 16'h0000;
    mem_ready = 1'b0; mem_data = 16'h0000;
    #1;
    checks++;
    if ({mem_req, IRWrite, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 000", {mem_req, IRWrite, busy});
    end
    checks++;
    if (pc !== 16'h0000 || IR_in !== 16'h0000) begin
      fails++; $display("FAIL reset_regs: pc=%h ir=%h want 0000 0000", pc, IR_in);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    fetch_en = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || busy !== 1'b1 || IRWrite !== 1'b0) begin
      fails++; $display("FAIL basic_req: req=%b addr=%h busy=%b irw=%b want 1 0000 1 0", mem_req, mem_addr, busy, IRWrite);
    end
    fetch_en = 1'b0; mem_ready = 1'b1; mem_data = 16'h1234;
    tick();
    checks++;
    if (IRWrite !== 1'b1 || IR_in !== 16'h1234 || mem_req !== 1'b0) begin
      fails++; $display("FAIL basic_deliver: irw=%b ir=%h req=%b want 1 1234 0", IRWrite, IR_in, mem_req);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if (IRWrite !== 1'b0 || pc !== 16'h0002 || busy !== 1'b0 || IR_in !== 16'h1234) begin
      fails++; $display("FAIL basic_after: irw=%b pc=%h busy=%b ir=%h want 0 0002 0 1234", IRWrite, pc, busy, IR_in);
    end
  endtask

  task automatic test_wait_states();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0002 || IRWrite !== 1'b0) begin
        fails++; $display("FAIL wait_req%0d: req=%b addr=%h irw=%b want 1 0002 0", i, mem_req, mem_addr, IRWrite);
      end
      tick();
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
      fails++; $display("FAIL wait_req3: req=%b addr=%h want 1 0002", mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_data = 16'hABCD;
    tick();
    checks++;
    if (IRWrite !== 1'b1 || IR_in !== 16'hABCD) begin
      fails++; $display("FAIL wait_deliver: irw=%b ir=%h want 1 abcd", IRWrite, IR_in);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if (IRWrite !== 1'b0 || pc !== 16'h0004) begin
      fails++; $display("FAIL wait_after: irw=%b pc=%h want 0 0004", IRWrite, pc);
    end
  endtask

  task automatic test_redirect_in_req();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; pc_load = 1'b1; pc_next = 16'h0040;
    tick();
    checks++;
    if (mem_req !== 1'b1 || pc !== 16'h0040) begin
      fails++; $display("FAIL redir_hold: req=%b pc=%h want 1 0040", mem_req, pc);
    end
    pc_load = 1'b0; mem_ready = 1'b1; mem_data = 16'hDEAD;
    tick();
    checks++;
    if (IRWrite !== 1'b0 || busy !== 1'b0 || IR_in !== 16'hABCD || pc !== 16'h0040) begin
      fails++; $display("FAIL redir_drop: irw=%b busy=%b ir=%h pc=%h want 0 0 abcd 0040", IRWrite, busy, IR_in, pc);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if (IRWrite !== 1'b0) begin
      fails++; $display("FAIL redir_nopulse: irw=%b want 0", IRWrite);
    end
    fetch_en = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
      fails++; $display("FAIL redir_refetch: req=%b addr=%h want 1 0040", mem_req, mem_addr);
    end
    fetch_en = 1'b0; mem_ready = 1'b1; mem_data = 16'h5555;
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0042 || IR_in !== 16'h5555) begin
      fails++; $display("FAIL redir_next: pc=%h ir=%h want 0042 5555", pc, IR_in);
    end
  endtask

  task automatic test_redirect_with_ready();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; pc_load = 1'b1; pc_next = 16'h0200; mem_ready = 1'b1; mem_data = 16'h7777;
    tick();
    pc_load = 1'b0; mem_ready = 1'b0;
    checks++;
    if (IRWrite !== 1'b0 || busy !== 1'b0 || pc !== 16'h0200 || IR_in !== 16'h5555) begin
      fails++; $display("FAIL both_drop: irw=%b busy=%b pc=%h ir=%h want 0 0 0200 5555", IRWrite, busy, pc, IR_in);
    end
  endtask

  task automatic test_wrap_and_deliver_load();
    pc_load = 1'b1; pc_next = 16'hFFFE;
    tick();
    pc_load = 1'b0;
    checks++;
    if (pc !== 16'hFFFE || busy !== 1'b0) begin
      fails++; $display("FAIL idle_load: pc=%h busy=%b want fffe 0", pc, busy);
    end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; mem_ready = 1'b1; mem_data = 16'h1111;
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0000 || IR_in !== 16'h1111) begin
      fails++; $display("FAIL wrap: pc=%h ir=%h want 0000 1111", pc, IR_in);
    end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; mem_ready = 1'b1; mem_data = 16'h2222;
    tick();
    mem_ready = 1'b0; pc_load = 1'b1; pc_next = 16'h0100;
    checks++;
    if (IRWrite !== 1'b1 || IR_in !== 16'h2222) begin
      fails++; $display("FAIL deliver_load_pulse: irw=%b ir=%h want 1 2222", IRWrite, IR_in);
    end
    tick();
    pc_load = 1'b0;
    checks++;
    if (pc !== 16'h0100 || IRWrite !== 1'b0) begin
      fails++; $display("FAIL deliver_load_pc: pc=%h irw=%b want 0100 0", pc, IRWrite);
    end
  endtask

  task automatic test_reset_mid_req();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, IRWrite, busy} !== 3'b000 || pc !== 16'h0000 || IR_in !== 16'h0000) begin
      fails++; $display("FAIL async_reset: ctrl=%b pc=%h ir=%h want 000 0000 0000", {mem_req, IRWrite, busy}, pc, IR_in);
    end
    #2 reset_n = 1'b1;
    mem_ready = 1'b1; mem_data = 16'h9999;
    tick(); tick();
    mem_ready = 1'b0;
    checks++;
    if (IRWrite !== 1'b0 || busy !== 1'b0 || IR_in !== 16'h0000) begin
      fails++; $display("FAIL late_ready: irw=%b busy=%b ir=%h want 0 0 0000", IRWrite, busy, IR_in);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (mem_req !== 1'b1 || timeout !== 1'b0) begin
      fails++; $display("FAIL to_pending: req=%b to=%b want 1 0", mem_req, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || IRWrite !== 1'b0) begin
      fails++; $display("FAIL to_fire: to=%b busy=%b irw=%b want 1 0 0", timeout, busy, IRWrite);
    end
    tick(); tick(); tick();
    checks++;
    if (timeout !== 1'b1) begin
      fails++; $display("FAIL to_sticky: to=%b want 1", timeout);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (timeout !== 1'b0) begin
      fails++; $display("FAIL to_reset: to=%b want 0", timeout);
    end
    reset_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_redirect_in_req();
    test_redirect_with_ready();
    test_wrap_and_deliver_load();
    test_reset_mid_req();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish want finish before 100000");
    $fatal(1);
  end

endmodule
